// File: rtl/lcd_window_writer_if.sv
// Pixel-stream and 8080 parallel LCD bus bundle for lcd_window_writer.
// The master side is the writer; the slave side is the pixel source plus the panel.
interface lcd_window_writer_if;
    logic [15:0] pix_data_i;
    logic        pix_valid_i;
    logic        pix_ready_o;
    logic        lcd_cs_o;
    logic        lcd_rs_o;
    logic        lcd_wr_o;
    logic        lcd_rd_o;
    logic [15:0] lcd_data_o;

    modport master (
        input  pix_data_i, pix_valid_i,
        output pix_ready_o, lcd_cs_o, lcd_rs_o, lcd_wr_o, lcd_rd_o, lcd_data_o
    );

    modport slave (
        output pix_data_i, pix_valid_i,
        input  pix_ready_o, lcd_cs_o, lcd_rs_o, lcd_wr_o, lcd_rd_o, lcd_data_o
    );
endinterface

// File: rtl/lcd_window_writer.sv
// Latches an X/Y window, issues 0x2A/0x2B/0x2C with params on an 8080 bus,
// then streams width*height pixels from a valid/ready source and pulses done.
module lcd_window_writer #(
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [63:0] set_x_i,
    input  logic [63:0] set_y_i,
    output logic        busy_o,
    output logic        done_o,
    lcd_window_writer_if.master bus
);

    localparam int WORD_CYC = WR_LOW_CYC + WR_HIGH_CYC;
    localparam int PH_W     = (WORD_CYC > 1) ? $clog2(WORD_CYC) : 1;
    localparam logic [PH_W-1:0] PH_LOW  = PH_W'(WR_LOW_CYC);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(WORD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_CMD, S_PIX_WAIT, S_PIX_WR, S_DONE
    } state_t;

    state_t          state, state_n;
    logic [3:0]      idx, idx_n;
    logic [PH_W-1:0] ph, ph_n;
    logic [16:0]     cnt, cnt_n;
    logic [63:0]     win_x, win_x_n, win_y, win_y_n;
    logic [15:0]     pix, pix_n;
    logic            busy_q, done_q, ready_q, cs_q, rs_q, wr_q;
    logic            busy_n, done_n, ready_n, cs_n, rs_n, wr_n;
    logic [15:0]     data_q, data_n;
    logic            word_end;

    function automatic logic [16:0] extent(input logic [15:0] sc, input logic [15:0] ec);
        return (ec >= sc) ? ({1'b0, ec} - {1'b0, sc} + 17'd1) : 17'd0;
    endfunction

    function automatic logic [15:0] cmd_word(input logic [3:0] i,
                                             input logic [63:0] x, input logic [63:0] y);
        case (i)
            4'd0:    return 16'h002A;
            4'd1:    return x[63:48];
            4'd2:    return x[47:32];
            4'd3:    return x[31:16];
            4'd4:    return x[15:0];
            4'd5:    return 16'h002B;
            4'd6:    return y[63:48];
            4'd7:    return y[47:32];
            4'd8:    return y[31:16];
            4'd9:    return y[15:0];
            default: return 16'h002C;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_n  = state;
        idx_n    = idx;
        ph_n     = ph;
        cnt_n    = cnt;
        win_x_n  = win_x;
        win_y_n  = win_y;
        pix_n    = pix;
        word_end = (ph == PH_LAST);

        unique case (state)
            S_IDLE: if (start_i) begin
                win_x_n = set_x_i;
                win_y_n = set_y_i;
                state_n = S_LATCH;
            end
            S_LATCH: begin
                cnt_n   = extent({win_x[55:48], win_x[39:32]}, {win_x[23:16], win_x[7:0]})
                        * extent({win_y[55:48], win_y[39:32]}, {win_y[23:16], win_y[7:0]});
                idx_n   = 4'd0;
                ph_n    = '0;
                state_n = S_CMD;
            end
            S_CMD: begin
                ph_n = word_end ? '0 : ph + 1'b1;
                if (word_end) begin
                    if (idx == 4'd10) state_n = (cnt != 17'd0) ? S_PIX_WAIT : S_DONE;
                    else              idx_n   = idx + 4'd1;
                end
            end
            S_PIX_WAIT: if (bus.pix_valid_i && ready_q) begin
                pix_n   = bus.pix_data_i;
                ph_n    = '0;
                state_n = S_PIX_WR;
            end
            S_PIX_WR: begin
                ph_n = word_end ? '0 : ph + 1'b1;
                if (word_end) begin
                    cnt_n   = cnt - 17'd1;
                    state_n = (cnt == 17'd1) ? S_DONE : S_PIX_WAIT;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Bus outputs are decoded from the next state and registered, so the strobe is glitch-free.
        busy_n  = (state_n != S_IDLE);
        done_n  = (state_n == S_DONE);
        ready_n = (state_n == S_PIX_WAIT);
        cs_n    = !(state_n inside {S_CMD, S_PIX_WAIT, S_PIX_WR});
        wr_n    = !((state_n inside {S_CMD, S_PIX_WR}) && (ph_n < PH_LOW));
        data_n  = data_q;
        rs_n    = rs_q;
        if (state_n == S_CMD) begin
            data_n = cmd_word(idx_n, win_x, win_y);
            rs_n   = !(idx_n inside {4'd0, 4'd5, 4'd10});
        end else if (state_n == S_PIX_WR) begin
            data_n = pix_n;
            rs_n   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            cs_q    <= 1'b1;
            rs_q    <= 1'b1;
            wr_q    <= 1'b1;
            data_q  <= 16'h0000;
        end else begin
            state   <= state_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            ready_q <= ready_n;
            cs_q    <= cs_n;
            rs_q    <= rs_n;
            wr_q    <= wr_n;
            data_q  <= data_n;
        end
    end

    // NOTE: datapath registers are left unreset; each is loaded before the FSM ever reads it.
    always_ff @(posedge clk_i) begin
        idx   <= idx_n;
        ph    <= ph_n;
        cnt   <= cnt_n;
        win_x <= win_x_n;
        win_y <= win_y_n;
        pix   <= pix_n;
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign bus.pix_ready_o = ready_q;
    assign bus.lcd_cs_o    = cs_q;
    assign bus.lcd_rs_o    = rs_q;
    assign bus.lcd_wr_o    = wr_q;
    assign bus.lcd_rd_o    = 1'b1;
    assign bus.lcd_data_o  = data_q;

endmodule

// File: tb/tb_lcd_window_writer.sv
// Bench for lcd_window_writer: a negedge bus monitor collects words on wr rising edges,
// a window model predicts the command/pixel word list, and directed steps drive random traffic.
module tb_lcd_window_writer;

    localparam int WR_LOW  = 2;
    localparam int WR_HIGH = 2;
    localparam int CMD_END = 2 + 11 * (WR_LOW + WR_HIGH);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] set_x = '0;
    logic [63:0] set_y = '0;
    logic        busy, done;

    lcd_window_writer_if bus ();

    lcd_window_writer #(.WR_LOW_CYC(WR_LOW), .WR_HIGH_CYC(WR_HIGH)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(start),
        .set_x_i(set_x),
        .set_y_i(set_y),
        .busy_o (busy),
        .done_o (done),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: a word is what the panel sees at the wr rising edge.
    logic [16:0] got[$];
    int bad_low_cnt = 0, unstable_cnt = 0, cs_bad_cnt = 0, short_high_cnt = 0, ready_cnt = 0;
    int low_run = 0, high_run = 99;
    logic [15:0] hold_d;
    logic        hold_rs;

    always @(negedge clk) begin
        if (rst) begin
            low_run  = 0;
            high_run = 99;
        end else begin
            if (bus.pix_ready_o === 1'b1) ready_cnt++;
            if (bus.lcd_wr_o === 1'b0) begin
                if (low_run == 0) begin
                    hold_d  = bus.lcd_data_o;
                    hold_rs = bus.lcd_rs_o;
                    if (high_run < WR_HIGH) short_high_cnt++;
                end else if (bus.lcd_data_o !== hold_d || bus.lcd_rs_o !== hold_rs) begin
                    unstable_cnt++;
                end
                if (bus.lcd_cs_o !== 1'b0) cs_bad_cnt++;
                low_run++;
                high_run = 0;
            end else begin
                if (low_run != 0) begin
                    if (low_run != WR_LOW) bad_low_cnt++;
                    if (bus.lcd_data_o !== hold_d || bus.lcd_rs_o !== hold_rs) unstable_cnt++;
                    if (bus.lcd_cs_o !== 1'b0) cs_bad_cnt++;
                    got.push_back({hold_rs, hold_d});
                end
                low_run = 0;
                high_run++;
            end
        end
    end

    // Reference model of the window arithmetic.
    function automatic int extent(input logic [63:0] w);
        int sc, ec;
        sc = int'({w[55:48], w[39:32]});
        ec = int'({w[23:16], w[7:0]});
        return (ec >= sc) ? ec - sc + 1 : 0;
    endfunction

    function automatic int model_count(input logic [63:0] x, input logic [63:0] y);
        return (extent(x) * extent(y)) % 131072;
    endfunction

    function automatic logic [63:0] rand_window(input int ext);
        logic [15:0] sc, ec;
        sc = 16'($urandom_range(8, 400));
        if (ext > 0) ec = sc + 16'(ext - 1);
        else         ec = sc - 16'($urandom_range(1, 7));
        return {8'($urandom), sc[15:8], 8'($urandom), sc[7:0],
                8'($urandom), ec[15:8], 8'($urandom), ec[7:0]};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_ready"}, bus.pix_ready_o, 1'b0);
        check({tag, "_cs"}, bus.lcd_cs_o, 1'b1);
        check({tag, "_wr"}, bus.lcd_wr_o, 1'b1);
        check({tag, "_rd"}, bus.lcd_rd_o, 1'b1);
    endtask

    // Runs one transaction; entered and left one time step after a rising edge.
    task automatic run_txn(input string tag, input logic [63:0] x, input logic [63:0] y,
                           input int valid_pct, input bit noise, input int abort_at);
        int n, base, c, hs, first_rdy, done_cyc, busy_bad, limit;
        int lo0, un0, cs0, sh0, rd0;
        bit hs_now;
        logic [15:0] pixq[$];
        logic [16:0] expq[$];
        logic [31:0] obs;

        n = model_count(x, y);
        for (int i = 0; i < n; i++) pixq.push_back(16'($urandom));
        expq.push_back({1'b0, 16'h002A});
        expq.push_back({1'b1, x[63:48]}); expq.push_back({1'b1, x[47:32]});
        expq.push_back({1'b1, x[31:16]}); expq.push_back({1'b1, x[15:0]});
        expq.push_back({1'b0, 16'h002B});
        expq.push_back({1'b1, y[63:48]}); expq.push_back({1'b1, y[47:32]});
        expq.push_back({1'b1, y[31:16]}); expq.push_back({1'b1, y[15:0]});
        expq.push_back({1'b0, 16'h002C});
        for (int i = 0; i < n; i++) expq.push_back({1'b1, pixq[i]});

        base = got.size();
        lo0 = bad_low_cnt; un0 = unstable_cnt; cs0 = cs_bad_cnt; sh0 = short_high_cnt; rd0 = ready_cnt;
        limit = 200 + n * 60;
        c = 0; hs = 0; first_rdy = -1; done_cyc = -1; busy_bad = 0;

        set_x = x;
        set_y = y;
        start = 1'b1;
        bus.pix_valid_i = ($urandom_range(0, 99) < valid_pct);
        bus.pix_data_i  = (n > 0) ? pixq[0] : 16'($urandom);

        while (done_cyc < 0 && c < limit) begin
            @(negedge clk);
            if (busy !== (c >= 1)) busy_bad++;
            if (bus.pix_ready_o === 1'b1 && first_rdy < 0) first_rdy = c;
            hs_now = (bus.pix_valid_i === 1'b1) && (bus.pix_ready_o === 1'b1);
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            @(posedge clk);
            #1;
            if (hs_now) hs++;
            start = noise && ($urandom_range(0, 7) == 0);
            if (noise) begin
                set_x = {$urandom, $urandom};
                set_y = {$urandom, $urandom};
            end
            bus.pix_valid_i = ($urandom_range(0, 99) < valid_pct);
            bus.pix_data_i  = (hs < n) ? pixq[hs] : 16'($urandom);
            c++;
            if (abort_at >= 0 && hs == abort_at) begin
                rst   = 1'b1;
                start = 1'b0;
                @(posedge clk);
                #1;
                check({tag, "_abort_cs"}, bus.lcd_cs_o, 1'b1);
                check({tag, "_abort_wr"}, bus.lcd_wr_o, 1'b1);
                check({tag, "_abort_busy"}, busy, 1'b0);
                check({tag, "_abort_ready"}, bus.pix_ready_o, 1'b0);
                check({tag, "_abort_data"}, bus.lcd_data_o, 16'h0000);
                rst = 1'b0;
                bus.pix_valid_i = 1'b0;
                return;
            end
        end

        check({tag, "_done_seen"}, (done_cyc >= 0), 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        bus.pix_valid_i = 1'b0;
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_cs_after"}, bus.lcd_cs_o, 1'b1);
        repeat (6) @(posedge clk);
        #1;

        check({tag, "_busy_window"}, busy_bad, 0);
        check({tag, "_handshakes"}, hs, n);
        check({tag, "_nwords"}, got.size() - base, expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            obs = (base + i < got.size()) ? 32'(got[base + i]) : 32'hFFFF_FFFF;
            check($sformatf("%s_word%0d", tag, i), obs, 32'(expq[i]));
        end
        check({tag, "_wr_low_len"}, bad_low_cnt - lo0, 0);
        check({tag, "_wr_high_len"}, short_high_cnt - sh0, 0);
        check({tag, "_word_stable"}, unstable_cnt - un0, 0);
        check({tag, "_cs_during_wr"}, cs_bad_cnt - cs0, 0);
        if (n == 0) begin
            check({tag, "_no_ready"}, ready_cnt - rd0, 0);
            check({tag, "_done_latency"}, done_cyc, CMD_END);
        end else begin
            check({tag, "_first_ready"}, first_rdy, CMD_END);
            if (valid_pct >= 100)
                check({tag, "_done_latency"}, done_cyc, CMD_END + n * (1 + WR_LOW + WR_HIGH));
        end
    endtask

    initial begin
        int rd0, nw0, busy_seen;
        bus.pix_valid_i = 1'b0;
        bus.pix_data_i  = 16'h0000;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_rs", bus.lcd_rs_o, 1'b1);
        check("reset_data", bus.lcd_data_o, 16'h0000);

        rd0 = ready_cnt;
        nw0 = got.size();
        repeat (10) @(posedge clk);
        #1;
        check_idle_outputs("idle");
        check("idle_ready_cycles", ready_cnt - rd0, 0);
        check("idle_words", got.size() - nw0, 0);

        run_txn("square", 64'h0000_0000_0000_004F, 64'h0000_0000_0000_004F, 100, 1'b0, -1);
        run_txn("offset", 64'h0000_00A0_0000_00EF, 64'h0000_00F0_0001_003F, 100, 1'b0, -1);
        run_txn("empty",  64'h0000_009F_0000_0050, 64'h0000_0000_0000_004F, 100, 1'b0, -1);

        for (int t = 0; t < 6; t++)
            run_txn($sformatf("rnd%0d", t),
                    rand_window(int'($urandom_range(0, 6))),
                    rand_window(int'($urandom_range(1, 5))), 55, 1'b1, -1);

        // Reset and start together: reset must win.
        nw0 = got.size();
        busy_seen = 0;
        start = 1'b1;
        rst   = 1'b1;
        set_x = 64'h0000_0000_0000_0003;
        set_y = 64'h0000_0000_0000_0003;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (busy === 1'b1) busy_seen++;
        end
        check("rst_start_busy", busy_seen, 0);
        check("rst_start_words", got.size() - nw0, 0);
        @(posedge clk);
        #1;

        run_txn("abort", rand_window(5), rand_window(4), 80, 1'b0, 7);
        repeat (3) @(posedge clk);
        #1;
        run_txn("after_abort", rand_window(4), rand_window(3), 70, 1'b1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
